// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, receiver state encoding and
// the decoded pixel payload.
package tmds_pkg;

  localparam int unsigned SYM_W   = 10;
  localparam int unsigned OFS_W   = 4;
  localparam int unsigned NUM_OFS = 10;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef logic [OFS_W-1:0] ofs_t;

  typedef struct packed {
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
  } pix_t;

  // Bit offset walks 0..NUM_OFS-1 and wraps.
  function automatic ofs_t next_ofs(input ofs_t o);
    return (o == OFS_W'(NUM_OFS - 1)) ? '0 : o + ofs_t'(1);
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into control
// token / video data.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output logic             is_ctrl_c,
  output logic [1:0]       cd_c,
  output logic [7:0]       data_c
);

  logic [7:0] d;

  always_comb begin
    is_ctrl_c = 1'b1;
    cd_c      = 2'b00;
    case (sym)
      CTRL_TOKEN_00: cd_c = 2'b00;
      CTRL_TOKEN_01: cd_c = 2'b01;
      CTRL_TOKEN_10: cd_c = 2'b10;
      CTRL_TOKEN_11: cd_c = 2'b11;
      default:       is_ctrl_c = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d         = sym[9] ? ~sym[7:0] : sym[7:0];
    data_c    = '0;
    data_c[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data_c[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment from control-token runs,
// lock supervision and registered symbol decode.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned LOCK_RUN      = 8,
  parameter int unsigned LOSS_WINDOW   = 4096
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [SYM_W-1:0] TMDS_in,
  output logic [7:0]       VD,
  output logic [1:0]       CD,
  output logic             VDE,
  output logic             LOCKED,
  output logic [OFS_W-1:0] ALIGN_OFS
);

  localparam int unsigned MAX_A = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
  localparam int unsigned MAX_C = (MAX_A > LOCK_RUN) ? MAX_A : LOCK_RUN;
  localparam int unsigned CNT_W = $clog2(MAX_C + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  logic [SYM_W-1:0]   prev;
  logic [SYM_W-1:0]   sym;
  logic [2*SYM_W-1:0] win;
  state_t             state, state_nxt;
  ofs_t               ofs_nxt;
  cnt_t               cyc, cyc_nxt, run, run_nxt, gap, gap_nxt, run_inc;
  pix_t               out_nxt;
  logic               is_ctrl;
  logic [1:0]         dec_cd;
  logic [7:0]         dec_data;

  assign win = {TMDS_in, prev};

  tmds_symbol_decode u_dec (
    .sym       (sym),
    .is_ctrl_c (is_ctrl),
    .cd_c      (dec_cd),
    .data_c    (dec_data)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev      <= '0;
      sym       <= '0;
      state     <= ST_SEARCH;
      ALIGN_OFS <= '0;
      cyc       <= '0;
      run       <= '0;
      gap       <= '0;
      VD        <= '0;
      CD        <= '0;
      VDE       <= 1'b0;
      LOCKED    <= 1'b0;
    end else begin
      prev      <= TMDS_in;
      sym       <= SYM_W'(win >> ALIGN_OFS);
      state     <= state_nxt;
      ALIGN_OFS <= ofs_nxt;
      cyc       <= cyc_nxt;
      run       <= run_nxt;
      gap       <= gap_nxt;
      VD        <= out_nxt.vd;
      CD        <= out_nxt.cd;
      VDE       <= out_nxt.vde;
      LOCKED    <= (state_nxt == ST_LOCKED);
    end
  end

  // Next state, counters and outputs; a lock in the same cycle as a window
  // expiry wins so the offset is kept.
  always_comb begin
    state_nxt = state;
    ofs_nxt   = ALIGN_OFS;
    cyc_nxt   = cyc;
    run_nxt   = run;
    gap_nxt   = gap;
    run_inc   = sat_inc(run);
    out_nxt   = '0;

    case (state)
      ST_SEARCH: begin
        cyc_nxt = sat_inc(cyc);
        run_nxt = is_ctrl ? run_inc : '0;
        if (is_ctrl && (run_inc >= CNT_W'(LOCK_RUN))) begin
          state_nxt = ST_LOCKED;
          cyc_nxt   = '0;
          run_nxt   = '0;
          gap_nxt   = '0;
        end else if (cyc == CNT_W'(SEARCH_WINDOW - 1)) begin
          ofs_nxt = next_ofs(ALIGN_OFS);
          cyc_nxt = '0;
          run_nxt = '0;
        end
      end
      ST_LOCKED: begin
        gap_nxt = is_ctrl ? '0 : sat_inc(gap);
        if (!is_ctrl && (gap == CNT_W'(LOSS_WINDOW - 1))) begin
          state_nxt = ST_SEARCH;
          cyc_nxt   = '0;
          run_nxt   = '0;
          gap_nxt   = '0;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase

    if (state_nxt == ST_LOCKED) begin
      if (is_ctrl) begin
        out_nxt.cd = dec_cd;
      end else begin
        out_nxt.vd  = dec_data;
        out_nxt.cd  = CD;
        out_nxt.vde = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a DVI encoder model feeds a
// bit-shifted serial stream; expected pixels go through a scoreboard queue.
module tb_tmds_channel_decoder;

  localparam int unsigned SW = 32;
  localparam int unsigned LR = 8;
  localparam int unsigned LW = 2048;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       CLK;
  logic       RSTn;
  logic [9:0] TMDS_in;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       LOCKED;
  logic [3:0] ALIGN_OFS;

  tmds_channel_decoder #(
    .SEARCH_WINDOW (SW),
    .LOCK_RUN      (LR),
    .LOSS_WINDOW   (LW)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .TMDS_in   (TMDS_in),
    .VD        (VD),
    .CD        (CD),
    .VDE       (VDE),
    .LOCKED    (LOCKED),
    .ALIGN_OFS (ALIGN_OFS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       chk;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         shift  = 0;
  int         disp   = 0;
  logic [9:0] prev_sym = '0;
  logic [1:0] last_cd  = '0;
  logic       got_lock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return T00;
      2'b01:   return T01;
      2'b10:   return T10;
      default: return T11;
    endcase
  endfunction

  // Reference DVI encoder with running disparity.
  task automatic encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (!qm[8]) disp += n0q - n1q;
      else        disp += n1q - n0q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  // Drive one symbol into the shifted stream; compare the entry whose
  // 3-edge latency has elapsed.
  task automatic send(input logic [9:0] s, input logic chk, input logic [7:0] vd,
                      input logic [1:0] cd, input logic vde);
    logic [19:0] pair;
    exp_t e, got;
    pair     = {s, prev_sym};
    TMDS_in  = 10'(pair >> (10 - shift));
    prev_sym = s;
    e.chk = chk; e.vd = vd; e.cd = cd; e.vde = vde;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    if (sbq.size() == 3) begin
      got = sbq.pop_front();
      if (got.chk) check("sym", 32'({VD, CD, VDE}), 32'({got.vd, got.cd, got.vde}));
    end
  endtask

  task automatic send_tok(input logic [1:0] c, input logic chk);
    last_cd = c;
    send(token(c), chk, 8'h00, c, 1'b0);
  endtask

  task automatic send_dat(input logic [7:0] d, input logic chk);
    logic [9:0] q;
    encode(d, q);
    send(q, chk, d, last_cd, 1'b1);
  endtask

  task automatic do_reset();
    RSTn    = 1'b0;
    TMDS_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn     = 1'b1;
    prev_sym = '0;
    disp     = 0;
    last_cd  = '0;
    sbq.delete();
  endtask

  initial begin
    logic [7:0] vals [5];
    logic [7:0] d;
    logic [9:0] q;
    logic       hs, vs;

    vals[0] = 8'h00; vals[1] = 8'h55; vals[2] = 8'hAA; vals[3] = 8'hFF; vals[4] = 8'h10;
    RSTn    = 1'b1;
    TMDS_in = '0;
    #1 RSTn = 1'b0;
    #2 check("reset_outputs", 32'({VD, CD, VDE, LOCKED, ALIGN_OFS}), 32'd0);

    // Lock at offset 0
    do_reset();
    shift = 0;
    for (int i = 0; i < 16; i++) begin
      send_tok(2'b00, 1'b0);
      if (i == 8) check("lock_not_yet", 32'(LOCKED), 32'd0);
      if (i == 9) check("lock_edge", 32'(LOCKED), 32'd1);
    end
    check("lock_ofs0", 32'(ALIGN_OFS), 32'd0);
    check("lock_cd0", 32'(CD), 32'd0);
    check("lock_vde0", 32'(VDE), 32'd0);

    // Data decode at offset 0
    for (int i = 0; i < 5; i++) send_dat(vals[i], 1'b1);
    for (int i = 0; i < 3; i++) send_tok(2'b00, 1'b1);

    // Search across offsets with the stream shifted by 7
    do_reset();
    shift    = 7;
    got_lock = 1'b0;
    for (int i = 0; i < 400 && !got_lock; i++) begin
      send_tok(2'b01, 1'b0);
      if (i == 30) check("search_ofs_hold", 32'(ALIGN_OFS), 32'd0);
      if (i == 31) check("search_ofs_step1", 32'(ALIGN_OFS), 32'd1);
      if (i == 63) check("search_ofs_step2", 32'(ALIGN_OFS), 32'd2);
      got_lock = LOCKED;
    end
    check("search_locked", 32'(LOCKED), 32'd1);
    check("search_ofs7", 32'(ALIGN_OFS), 32'd7);
    check("search_cd01", 32'(CD), 32'd1);
    for (int i = 0; i < 20; i++) send_dat(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 3; i++) send_tok(2'b01, 1'b1);

    // Round trip of a blanking + active line at every shift
    for (int s = 0; s < 10; s++) begin
      do_reset();
      shift = s;
      for (int i = 0; i < 340; i++) send_tok(2'b00, 1'b0);
      check("line_locked", 32'(LOCKED), 32'd1);
      check("line_ofs", 32'(ALIGN_OFS), 32'(s));
      for (int i = 0; i < 370; i++) begin
        hs = (i >= 110 && i < 150);
        vs = (s % 2 == 1) && (i < 40);
        send_tok({vs, hs}, 1'b1);
      end
      for (int i = 0; i < 1280; i++) send_dat(8'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 3; i++) send_tok(2'b00, 1'b1);
    end

    // Loss of lock after LW token-free symbols (offset 9 from above)
    for (int i = 0; i < int'(LW) + 2; i++) begin
      d = 8'($urandom_range(0, 255));
      encode(d, q);
      if (i < int'(LW) - 1) send(q, 1'b1, d, last_cd, 1'b1);
      else                  send(q, 1'b1, 8'h00, 2'b00, 1'b0);
      if (i == int'(LW))     check("loss_not_yet", 32'(LOCKED), 32'd1);
      if (i == int'(LW) + 1) begin
        check("loss_edge", 32'(LOCKED), 32'd0);
        check("loss_vde", 32'(VDE), 32'd0);
        check("loss_ofs_kept", 32'(ALIGN_OFS), 32'd9);
      end
    end
    for (int i = 0; i < 12; i++) begin
      send_tok(2'b00, 1'b1);
      if (i == 8) check("relock_not_yet", 32'(LOCKED), 32'd0);
      if (i == 9) check("relock_edge", 32'(LOCKED), 32'd1);
    end
    check("relock_ofs", 32'(ALIGN_OFS), 32'd9);

    // Asynchronous reset while locked and showing data
    for (int i = 0; i < 4; i++) send_dat(8'hA5, 1'b0);
    check("pre_reset_vde", 32'(VDE), 32'd1);
    #1 RSTn = 1'b0;
    #1 check("async_reset", 32'({VD, CD, VDE, LOCKED, ALIGN_OFS}), 32'd0);

    // Lock coinciding with search-window expiry keeps the offset
    do_reset();
    shift = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= 22 && i < 30) send_tok(2'b00, 1'b0);
      else                   send_dat(8'($urandom_range(0, 255)), 1'b0);
      if (i == 30) check("tie_not_yet", 32'(LOCKED), 32'd0);
      if (i == 31) begin
        check("tie_locked", 32'(LOCKED), 32'd1);
        check("tie_ofs_kept", 32'(ALIGN_OFS), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
